// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller for the MEM stage.
// Services misses by writing back a dirty victim and refilling the line from off-chip memory.
module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [1:0]        dbg_state_o
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 5 - IDX_W;
  localparam int OFF_W = $clog2(LINE_W);

  // Off-chip handshake: mem_req_o is a level held with stable mem_we_o/mem_addr_o/mem_wdata_o
  // until the single-cycle mem_ack_i pulse; the transfer completes at the edge where ack is 1.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic                 refill_q;
  logic [31:0]          hit_cnt_q;
  logic [31:0]          miss_cnt_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [OFF_W-1:0] bit_off;
  logic             hit;
  logic             victim_dirty;
  logic             addr_unused;

  assign idx          = addr_i[5 +: IDX_W];
  assign req_tag      = addr_i[ADDR_W-1 -: TAG_W];
  assign bit_off      = OFF_W'({addr_i[4:2], 5'b00000});
  assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
  assign addr_unused  = ^addr_i[1:0];
  assign dbg_state_o  = state_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (req_i && !hit) state_d = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
      S_WRITEBACK: if (mem_ack_i) state_d = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ack_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_IDLE: begin
        stall_o = req_i && !hit;
        if (req_i && !we_i && hit) rdata_o = data_q[idx][bit_off +: 32];
      end
      S_WRITEBACK: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[idx], idx, 5'b00000};
        mem_wdata_o = data_q[idx];
      end
      S_ALLOCATE: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, idx, 5'b00000};
      end
      default: ;
    endcase
  end

  // Control state; the refill flag keeps the replayed access after a miss out of the hit count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i && hit) begin
            if (we_i) dirty_q[idx] <= 1'b1;
            if (!refill_q) hit_cnt_q <= hit_cnt_q + 32'd1;
            refill_q <= 1'b0;
          end else if (req_i) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
          end
        end
        S_WRITEBACK: if (mem_ack_i) dirty_q[idx] <= 1'b0;
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            refill_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits qualify every read of them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == S_IDLE && req_i && hit && we_i)
        data_q[idx][bit_off +: 32] <= wdata_i;
      if (state_q == S_ALLOCATE && mem_ack_i) begin
        data_q[idx] <= mem_rdata_i;
        tag_q[idx]  <= req_tag;
      end
    end
  end
endmodule
